pipeline_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage MIPS core. It takes the jump unit's redirect decision (pc_src, kill1, kill2), the load-use hazard inputs from ID/EX and IF/ID, and the data-memory busy signal. From these it drives the PC write enable, the pipeline register write enables, the flush lines and the final PC mux select. It also holds redirects that arrive during a memory freeze, and counts stall and flush cycles for debug.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/sat_counter.sv | 25 ++
 rtl/pipeline_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared encodings for the pipeline sequencing controller: FSM states,
// PC mux select values and the held-redirect record.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOADUSE = 2'd1,
    ST_FREEZE  = 2'd2
  } state_e;

  localparam logic [1:0] PC4    = 2'b00;
  localparam logic [1:0] JUMP   = 2'b01;
  localparam logic [1:0] BRANCH = 2'b10;

  typedef struct packed {
    logic [1:0] src;
    logic       k1;
    logic       k2;
  } redir_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall/flush debug counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_inc && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: arbitrates memory freeze, held redirects,
// live redirects and load-use bubbles into PC/pipe-register enables and flushes.
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_pc_src,
  input  logic             i_kill1,
  input  logic             i_kill2,
  input  logic             i_idex_memread,
  input  logic [REG_W-1:0] i_idex_rt,
  input  logic [REG_W-1:0] i_ifid_rs,
  input  logic [REG_W-1:0] i_ifid_rt,
  input  logic             i_mem_busy,
  output logic [1:0]       o_pc_src,
  output logic             o_pc_we,
  output logic             o_ifid_we,
  output logic             o_idex_we,
  output logic             o_exmem_we,
  output logic             o_memwb_we,
  output logic             o_ifid_flush,
  output logic             o_idex_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  state_e state_q, state_d;
  redir_t pend_q, pend_d;
  logic   pend_v_q, pend_v_d;
  logic   lu, rd;

  assign lu = i_idex_memread && (i_idex_rt != '0) &&
              ((i_idex_rt == i_ifid_rs) || (i_idex_rt == i_ifid_rt));
  assign rd = i_kill1 | i_kill2;

  always_comb begin
    state_d      = ST_RUN;
    pend_d       = pend_q;
    pend_v_d     = pend_v_q;
    o_pc_src     = PC4;
    o_pc_we      = 1'b1;
    o_ifid_we    = 1'b1;
    o_idex_we    = 1'b1;
    o_exmem_we   = 1'b1;
    o_memwb_we   = 1'b1;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;

    if (i_mem_busy) begin
      state_d    = ST_FREEZE;
      o_pc_we    = 1'b0;
      o_ifid_we  = 1'b0;
      o_idex_we  = 1'b0;
      o_exmem_we = 1'b0;
      o_memwb_we = 1'b0;
      // Only the first redirect seen during a freeze is kept.
      if (rd && !pend_v_q) begin
        pend_d   = '{src: i_pc_src, k1: i_kill1, k2: i_kill2};
        pend_v_d = 1'b1;
      end
    end else if (pend_v_q) begin
      // Held redirect wins over any live one arriving on the release cycle.
      o_pc_src     = pend_q.src;
      o_ifid_flush = pend_q.k1;
      o_idex_flush = pend_q.k2;
      pend_v_d     = 1'b0;
    end else if (rd) begin
      o_pc_src     = i_pc_src;
      o_ifid_flush = i_kill1;
      o_idex_flush = i_kill2;
    end else if (lu && (state_q != ST_LOADUSE)) begin
      state_d      = ST_LOADUSE;
      o_pc_we      = 1'b0;
      o_ifid_we    = 1'b0;
      o_idex_flush = 1'b1;
    end

    if (i_rst) begin
      o_pc_src     = PC4;
      o_pc_we      = 1'b0;
      o_ifid_we    = 1'b0;
      o_idex_we    = 1'b0;
      o_exmem_we   = 1'b0;
      o_memwb_we   = 1'b0;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= ST_RUN;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc (!o_pc_we && !i_rst),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_inc ((o_ifid_flush || o_idex_flush) && !i_rst),
    .o_cnt (o_flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: driver queues hand-computed responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pc_src;
  logic       k1, k2, mr, busy, busy2;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;

  logic [1:0]  o_src, o2_src;
  logic        o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we, o_ifl, o_xfl;
  logic        o2_pc_we, o2_ifid_we, o2_idex_we, o2_exmem_we, o2_memwb_we, o2_ifl, o2_xfl;
  logic [15:0] o_sc, o_fc;
  logic [2:0]  o2_sc, o2_fc;

  typedef struct packed {
    logic [1:0]  src;
    logic [4:0]  we;
    logic [1:0]  fl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  exp_t       q[$];
  logic [2:0] q2[$];
  logic       chk_v = 1'b0, chk2_v = 1'b0;
  int         n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(16), .REG_W(5)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc_src(pc_src), .i_kill1(k1), .i_kill2(k2),
    .i_idex_memread(mr), .i_idex_rt(idex_rt), .i_ifid_rs(ifid_rs), .i_ifid_rt(ifid_rt),
    .i_mem_busy(busy), .o_pc_src(o_src), .o_pc_we(o_pc_we), .o_ifid_we(o_ifid_we),
    .o_idex_we(o_idex_we), .o_exmem_we(o_exmem_we), .o_memwb_we(o_memwb_we),
    .o_ifid_flush(o_ifl), .o_idex_flush(o_xfl), .o_stall_cnt(o_sc), .o_flush_cnt(o_fc)
  );

  pipeline_ctrl #(.CNT_W(3), .REG_W(5)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_pc_src(2'b00), .i_kill1(1'b0), .i_kill2(1'b0),
    .i_idex_memread(1'b0), .i_idex_rt(5'd0), .i_ifid_rs(5'd0), .i_ifid_rt(5'd0),
    .i_mem_busy(busy2), .o_pc_src(o2_src), .o_pc_we(o2_pc_we), .o_ifid_we(o2_ifid_we),
    .o_idex_we(o2_idex_we), .o_exmem_we(o2_exmem_we), .o_memwb_we(o2_memwb_we),
    .o_ifid_flush(o2_ifl), .o_idex_flush(o2_xfl), .o_stall_cnt(o2_sc), .o_flush_cnt(o2_fc)
  );

  function automatic exp_t mk(logic [1:0] s, logic [4:0] we, logic [1:0] fl, int sc, int fc);
    exp_t e;
    e.src = s; e.we = we; e.fl = fl; e.sc = 16'(sc); e.fc = 16'(fc);
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic drv(logic [1:0] s, logic a, logic b, logic m, logic [4:0] rt,
                     logic [4:0] rs, logic [4:0] irt, logic bz);
    pc_src = s; k1 = a; k2 = b; mr = m; idex_rt = rt; ifid_rs = rs; ifid_rt = irt; busy = bz;
  endtask

  task automatic vec(exp_t e);
    q.push_back(e);
    chk_v = 1'b1;
    cyc();
    chk_v = 1'b0;
  endtask

  // Monitor: compares on every negedge where the driver presented a vector.
  always @(negedge clk) begin
    exp_t e, a;
    logic [2:0] e2;
    if (chk_v) begin
      n_vec++;
      a = {o_src, {o_pc_we, o_ifid_we, o_idex_we, o_exmem_we, o_memwb_we},
           {o_ifl, o_xfl}, o_sc, o_fc};
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow at %0t", $time);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          n_err++;
          $display("FAIL vec%0d got src=%b we=%b fl=%b sc=%0d fc=%0d want src=%b we=%b fl=%b sc=%0d fc=%0d",
                   n_vec, a.src, a.we, a.fl, a.sc, a.fc, e.src, e.we, e.fl, e.sc, e.fc);
        end
      end
    end
    if (chk2_v) begin
      n_vec++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL sat_underflow at %0t", $time);
      end else begin
        e2 = q2.pop_front();
        if (o2_sc !== e2) begin
          n_err++;
          $display("FAIL sat_stall_cnt got %0d want %0d", o2_sc, e2);
        end
      end
    end
  end

  localparam logic [4:0] ALL = 5'b11111, NONE = 5'b00000, BUB = 5'b00111;

  initial begin
    rst = 1'b1; busy2 = 1'b0;
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0);
    cyc();
    // Reset held three cycles
    repeat (3) vec(mk(2'b00, NONE, 2'b11, 0, 0));
    rst = 1'b0;
    vec(mk(2'b00, ALL, 2'b00, 0, 0));
    // Load-use: one bubble, then normal even though lu persists
    drv(2'b00, 0, 0, 1, 5, 5, 0, 0);
    vec(mk(2'b00, BUB, 2'b01, 0, 0));
    vec(mk(2'b00, ALL, 2'b00, 1, 1));
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0);
    vec(mk(2'b00, ALL, 2'b00, 1, 1));
    // rt = 0 never hazards
    drv(2'b00, 0, 0, 1, 0, 0, 0, 0);
    vec(mk(2'b00, ALL, 2'b00, 1, 1));
    // Branch overrides a simultaneous load-use
    drv(2'b10, 1, 1, 1, 5, 5, 0, 0);
    vec(mk(2'b10, ALL, 2'b11, 1, 1));
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0);
    vec(mk(2'b00, ALL, 2'b00, 1, 2));
    // Jump latched during freeze; later branch ignored
    drv(2'b01, 1, 0, 0, 0, 0, 0, 1);
    vec(mk(2'b00, NONE, 2'b00, 1, 2));
    drv(2'b10, 1, 1, 0, 0, 0, 0, 1);
    vec(mk(2'b00, NONE, 2'b00, 2, 2));
    drv(2'b00, 0, 0, 0, 0, 0, 0, 1);
    vec(mk(2'b00, NONE, 2'b00, 3, 2));
    vec(mk(2'b00, NONE, 2'b00, 4, 2));
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0);
    vec(mk(2'b01, ALL, 2'b10, 5, 2));
    vec(mk(2'b00, ALL, 2'b00, 5, 3));
    // Pending branch beats a live jump on release, applied once
    drv(2'b10, 1, 1, 0, 0, 0, 0, 1);
    vec(mk(2'b00, NONE, 2'b00, 5, 3));
    drv(2'b01, 1, 0, 0, 0, 0, 0, 0);
    vec(mk(2'b10, ALL, 2'b11, 6, 3));
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0);
    vec(mk(2'b00, ALL, 2'b00, 6, 4));
    // Reset during freeze discards the pending jump
    drv(2'b01, 1, 0, 0, 0, 0, 0, 1);
    vec(mk(2'b00, NONE, 2'b00, 6, 4));
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    vec(mk(2'b00, NONE, 2'b11, 0, 0));
    rst = 1'b0;
    vec(mk(2'b00, ALL, 2'b00, 0, 0));
    // Illegal select passes through
    drv(2'b11, 1, 0, 0, 0, 0, 0, 0);
    vec(mk(2'b11, ALL, 2'b10, 0, 0));
    drv(2'b00, 0, 0, 0, 0, 0, 0, 0);
    vec(mk(2'b00, ALL, 2'b00, 0, 1));
    // Saturation on the 3-bit instance
    busy2 = 1'b1;
    repeat (10) cyc();
    busy2 = 1'b0;
    q2.push_back(3'd7); chk2_v = 1'b1; cyc(); chk2_v = 1'b0;
    busy2 = 1'b1; cyc(); busy2 = 1'b0;
    q2.push_back(3'd7); chk2_v = 1'b1; cyc(); chk2_v = 1'b0;
    cyc();
    if (q.size() != 0 || q2.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got %0d want 0", q.size() + q2.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
